// File: rtl/rle_sel_decoder_pkg.sv
// Shared definitions for the run-length select decoder: widths, FSM encoding and
// the select codes that drive the downstream 4-to-1 multiplexer.
package rle_sel_decoder_pkg;
  localparam int SEL_W     = 2;
  localparam int CNT_W_DEF = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] SEL_IN0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_IN1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_IN2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_IN3 = 2'd3;
endpackage

// File: rtl/rle_run_counter.sv
// Loadable down-counter holding the symbols still owed for the current token.
// Saturates at zero so a stray decrement can never wrap the count.
module rle_run_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_zero
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign is_zero = (cnt_q == '0);
endmodule

// File: rtl/rle_sel_decoder.sv
// Expands (sel, run-1, last) tokens into one select symbol per transfer.
// A new token may load on the same edge as the final symbol of the previous run.
module rle_sel_decoder
  import rle_sel_decoder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W+1:0] in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             last_q, last_d;
  logic             cnt_zero;
  logic             accept, xfer, dec;

  assign out_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign in_ready  = (state_q == IDLE) || (cnt_zero && out_ready);
  assign out_last  = out_valid && last_q && cnt_zero;
  assign out_sel   = sel_q;

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid && out_ready;
  assign dec    = xfer && !cnt_zero;

  rle_run_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (in_data[CNT_W-1:0]),
    .dec      (dec),
    .is_zero  (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (accept) begin
      state_d = RUN;
      sel_d   = in_data[CNT_W+1:CNT_W];
      last_d  = in_last;
    end else if (xfer && cnt_zero) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_IN0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_rle_sel_decoder.sv
// Bench for rle_sel_decoder: directed scenarios plus random traffic, all checked
// against a symbol-queue model that expands each accepted token into its symbols.
module tb_rle_sel_decoder;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W+1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       out_sel;
  logic             out_last;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;
  int n_xfer = 0;
  int n_acc = 0;

  typedef struct packed {
    logic [1:0] sel;
    logic       last;
  } sym_t;
  sym_t q[$];

  always #5 clk = ~clk;

  rle_sel_decoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive after negedge, check against model, advance model at posedge.
  task automatic cyc(input logic v, input logic [1:0] sel, input logic [CNT_W-1:0] cnt,
                     input logic lst, input logic ordy);
    logic exp_vld, exp_rdy, acc, xf;
    @(negedge clk);
    in_valid  = v;
    in_data   = {sel, cnt};
    in_last   = lst;
    out_ready = ordy;
    #1;
    exp_vld = (q.size() != 0);
    exp_rdy = (q.size() == 0) || (q.size() == 1 && ordy);
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    chk("busy", 32'(busy), 32'(exp_vld));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (exp_vld) begin
      chk("out_sel", 32'(out_sel), 32'(q[0].sel));
      chk("out_last", 32'(out_last), 32'(q[0].last));
    end else begin
      chk("out_last_idle", 32'(out_last), 32'd0);
    end
    acc = v && exp_rdy;
    xf  = exp_vld && ordy;
    @(posedge clk);
    if (xf) begin
      void'(q.pop_front());
      n_xfer++;
    end
    if (acc) begin
      n_acc++;
      for (int i = 0; i <= int'(cnt); i++)
        q.push_back('{sel: sel, last: (i == int'(cnt)) && lst});
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, '0, 1'b0, ordy);
  endtask

  initial begin
    int x0;
    logic [1:0] rs;
    logic [CNT_W-1:0] rc;

    // Reset state, applied without any clock edge yet.
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Accept on the first edge after release; code 2, run 4, last.
    x0 = n_xfer;
    cyc(1'b1, 2'd2, 6'd3, 1'b1, 1'b1);
    idle(5, 1'b1);
    chk("run4_xfers", 32'(n_xfer - x0), 32'd4);

    // Back-to-back (1,0,0),(3,1,1) with no bubble.
    x0 = n_xfer;
    cyc(1'b1, 2'd1, 6'd0, 1'b0, 1'b1);
    cyc(1'b1, 2'd3, 6'd1, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("b2b_xfers", 32'(n_xfer - x0), 32'd3);

    // Stalling downstream: three transfers over toggling out_ready.
    x0 = n_xfer;
    cyc(1'b1, 2'd0, 6'd2, 1'b0, 1'b1);
    cyc(1'b0, 2'd0, '0, 1'b0, 1'b1);
    cyc(1'b0, 2'd0, '0, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, '0, 1'b0, 1'b1);
    cyc(1'b0, 2'd0, '0, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, '0, 1'b0, 1'b1);
    idle(2, 1'b1);
    chk("stall_xfers", 32'(n_xfer - x0), 32'd3);

    // Maximum run length.
    x0 = n_xfer;
    cyc(1'b1, 2'd1, 6'd63, 1'b1, 1'b1);
    idle(66, 1'b1);
    chk("max_xfers", 32'(n_xfer - x0), 32'd64);

    // Pending token must wait for the final symbol of the current run.
    x0 = n_acc;
    cyc(1'b1, 2'd3, 6'd2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd2, 6'd1, 1'b1, 1'b1);
    chk("pending_accepts", 32'(n_acc - x0), 32'd2);
    idle(3, 1'b1);

    // Asynchronous reset in the middle of a run.
    cyc(1'b1, 2'd3, 6'd5, 1'b1, 1'b1);
    cyc(1'b0, 2'd0, '0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_sel", 32'(out_sel), 32'd0);
    chk("mid_rst_out_last", 32'(out_last), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rs = 2'($urandom_range(0, 3));
      rc = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 4));
      cyc(1'($urandom_range(0, 1)), rs, rc, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) < 7));
    end
    idle(80, 1'b1);
    chk("final_drained", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rle_sel_decoder.md
RLE_SEL_DECODER -- requirements
Module: rle_sel_decoder

Interface
REQ-001 Parameter CNT_W, default 6: width of the run-count field; input word width is CNT_W+2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_data  input  CNT_W+2  compressed token: [CNT_W+1:CNT_W] = sel code, [CNT_W-1:0] = run length minus 1.
REQ-005 in_last  input  1  token is the final token of a frame.
REQ-006 in_valid  input  1  upstream token present.
REQ-007 in_ready  output  1  block accepts the token this cycle.
REQ-008 out_sel  output  2  select code driven to the downstream 4-to-1 multiplexer.
REQ-009 out_last  output  1  final symbol of a frame.
REQ-010 out_valid  output  1  out_sel/out_last hold a valid symbol.
REQ-011 out_ready  input  1  downstream consumes the symbol this cycle.
REQ-012 busy  output  1  state is RUN.

Function
REQ-013 A token is accepted on a rising edge where in_valid && in_ready; a symbol is transferred on a rising edge where out_valid && out_ready.
REQ-014 FSM states: IDLE (no token held) and RUN (token held, symbols remaining).
REQ-015 IDLE: in_ready=1, out_valid=0; on accept -> RUN, latch code into out_sel, latch count into remaining counter, latch in_last.
REQ-016 RUN: out_valid=1, out_sel = latched code, held stable while out_ready=0.
REQ-017 RUN: each transfer with remaining != 0 decrements remaining by 1; state stays RUN.
REQ-018 RUN: transfer with remaining == 0 ends the run; out_last = latched in_last && remaining == 0, combinationally valid for that final symbol only.
REQ-019 in_ready = (state==IDLE) || (state==RUN && remaining==0 && out_ready); ready depends on out_ready, never on in_valid.
REQ-020 Simultaneous end-of-run transfer and new accept: new token loads in the same edge, state stays RUN, no bubble cycle on out_valid.
REQ-021 End-of-run transfer without accept: -> IDLE, out_valid=0 next cycle.
REQ-022 Each token emits exactly count+1 symbols; count field 0 emits one symbol; max count (2^CNT_W-1) emits 2^CNT_W symbols.
REQ-023 Throughput: one symbol per cycle while out_ready=1 and tokens are available back-to-back.
REQ-024 Latency: token accepted at edge N -> first symbol out_valid=1 after edge N (visible in cycle N+1).
REQ-025 remaining counter never wraps; decrement is blocked at 0.
REQ-026 Inputs ignored (no state change) when in_ready=0, regardless of in_valid.

Reset
REQ-027 rst_n low forces immediately, without a clock: state=IDLE, remaining=0, out_sel=2'b00, latched last=0, out_valid=0, out_last=0, busy=0.
REQ-028 Reset mid-run discards the held token and remaining symbols; no partial symbol is emitted after release.
REQ-029 First accept possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package holds: SEL_W=2, default CNT_W=6, state encoding (IDLE=0, RUN=1), sel code constants SEL_IN0..SEL_IN3 = 0..3.
REQ-031 One sub-module rle_run_counter: loadable CNT_W-bit down-counter with load, dec, is_zero outputs; FSM and handshake stay in the top.
REQ-032 out_sel, state, remaining and latched last are registers; out_valid, in_ready, out_last derived from state only (plus out_ready for in_ready).

Verification
REQ-033 Token code=2, count=3, last=1, out_ready=1 -> out_sel=2 for 4 consecutive cycles, out_last=1 only on 4th, then out_valid=0.
REQ-034 Tokens (1,0,0),(3,1,1) back-to-back, out_ready=1 -> sel sequence 1,3,3 with no gap; out_last only on final 3.
REQ-035 Token (0,2,0), out_ready toggling 1,0,1,0,1 -> out_sel stays 0, exactly 3 transfers, in_ready high only with final transfer.
REQ-036 Token count=63 (CNT_W=6) -> exactly 64 symbols, counter reaches 0 without wrap.
REQ-037 rst_n pulled low at 2nd symbol of a count=5 run -> outputs reset asynchronously; after release out_valid=0 until next accept.
REQ-038 in_valid=1 while RUN with remaining>0 -> token not consumed; it is accepted on the final-symbol transfer edge.
